dsss_spreader: RTL and testbench

DSSS_SPREADER -- requirements
Module: dsss_spreader

---
 rtl/dsss_spreader.sv | 176 +++++++++++++++++
 tb/tb_dsss_spreader.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsss_spreader.sv
// Direct-sequence spreader: each accepted symbol bit is XORed with len_q code chips.
// The code is either a stored short PN code or a free-running long PN sequence.
module dsss_spreader #(
    parameter int                    MAX_SPREAD = 64,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 16'hB400,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [$clog2(MAX_SPREAD+1)-1:0]  i_spread_len,
    input  logic                             i_code_mode,
    input  logic                             i_reload,
    input  logic                             i_data,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic                             o_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_last,
    output logic                             o_code_ready
);

    localparam int LEN_W = $clog2(MAX_SPREAD + 1);
    localparam int CNT_W = (MAX_SPREAD > 1) ? $clog2(MAX_SPREAD) : 1;
    localparam logic [LFSR_WIDTH-1:0] SEED_EFF =
        (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_SEED;

    typedef enum logic [1:0] {
        ST_GEN  = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Handshake contract: a symbol moves on i_valid & o_ready, a chip moves on
    // o_valid & i_ready; o_data/o_last are stable while o_valid & !i_ready.

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [MAX_SPREAD-1:0]   code_q, code_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    mode_q, mode_d;
    logic                    sym_q, sym_d;
    logic                    pend_q, pend_d;

    logic [LEN_W-1:0]        len_clamped;
    logic                    cnt_is_last;
    logic                    accept;
    logic                    reload_now;
    logic                    chip;

    function automatic logic [LFSR_WIDTH-1:0] pn_next(input logic [LFSR_WIDTH-1:0] s);
        if (s == '0) begin
            return LFSR_WIDTH'(1);
        end
        return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
    endfunction

    always_comb begin
        len_clamped = i_spread_len;
        if (i_spread_len < LEN_W'(2)) begin
            len_clamped = LEN_W'(2);
        end else if (i_spread_len > LEN_W'(MAX_SPREAD)) begin
            len_clamped = LEN_W'(MAX_SPREAD);
        end
    end

    assign cnt_is_last = (LEN_W'(cnt_q) == (len_q - LEN_W'(1)));

    // Only the last-chip handshake may take a new symbol, and never while a reload waits.
    assign o_ready = ((state_q == ST_IDLE) && !i_reload) ||
                     ((state_q == ST_SEND) && cnt_is_last && i_ready && !pend_q && !i_reload);
    assign accept  = i_valid && o_ready;

    assign reload_now = (i_reload && (state_q != ST_SEND)) ||
                        ((state_q == ST_SEND) && cnt_is_last && i_ready && (pend_q || i_reload));

    assign chip         = mode_q ? lfsr_q[0] : code_q[cnt_q];
    assign o_valid      = (state_q == ST_SEND);
    assign o_data       = (state_q == ST_SEND) && (chip ^ sym_q);
    assign o_last       = (state_q == ST_SEND) && cnt_is_last;
    assign o_code_ready = (state_q != ST_GEN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        code_d  = code_q;
        len_d   = len_q;
        mode_d  = mode_q;
        sym_d   = sym_q;
        pend_d  = pend_q;

        unique case (state_q)
            ST_GEN: begin
                if (!mode_q) begin
                    code_d[cnt_q] = lfsr_q[0];
                    lfsr_d        = pn_next(lfsr_q);
                    if (cnt_is_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    sym_d   = i_data;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_reload) begin
                    pend_d = 1'b1;
                end
                if (i_ready) begin
                    if (mode_q) begin
                        lfsr_d = pn_next(lfsr_q);
                    end
                    if (cnt_is_last) begin
                        if (accept) begin
                            sym_d = i_data;
                            cnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_GEN;
                cnt_d   = '0;
            end
        endcase

        // A reload restarts from the seed with freshly sampled configuration.
        if (reload_now) begin
            state_d = ST_GEN;
            cnt_d   = '0;
            lfsr_d  = SEED_EFF;
            len_d   = len_clamped;
            mode_d  = i_code_mode;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_GEN;
            cnt_q   <= '0;
            lfsr_q  <= SEED_EFF;
            code_q  <= '0;
            len_q   <= len_clamped;
            mode_q  <= i_code_mode;
            sym_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            code_q  <= code_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            sym_q   <= sym_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_dsss_spreader.sv
// Bench for dsss_spreader: random symbols and configurations checked against a
// table-driven PN model, plus directed backpressure, clamp, reload and reset cases.
module tb_dsss_spreader;

    localparam int          MAX  = 64;
    localparam int          LW   = $clog2(MAX + 1);
    localparam logic [15:0] POLY = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [LW-1:0] i_spread_len = '0;
    logic          i_code_mode = 1'b0;
    logic          i_reload = 1'b0;
    logic          i_data = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b1;
    logic          o_ready, o_data, o_valid, o_last, o_code_ready;

    always #5 clk = ~clk;

    dsss_spreader dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_spread_len (i_spread_len),
        .i_code_mode  (i_code_mode),
        .i_reload     (i_reload),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_last       (o_last),
        .o_code_ready (o_code_ready)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] exp_q[$];   // {last, data} per chip
    logic [1:0] got_q[$];
    bit         sym_in[$];
    int         gaps;
    bit         stream_to;

    // Reference model: code table built from the PN rule, chips = code ^ symbol.
    bit          m_mode;
    int          m_len;
    bit          m_code[MAX];
    logic [15:0] m_lfsr;

    function automatic bit m_step();
        bit o;
        if (m_lfsr == 16'h0) begin
            m_lfsr = 16'h1;
            return 1'b0;
        end
        o = m_lfsr[0];
        m_lfsr = (m_lfsr >> 1) ^ (o ? POLY : 16'h0);
        return o;
    endfunction

    function automatic void model_config(input bit mode, input int raw_len);
        m_mode = mode;
        m_len  = (raw_len < 2) ? 2 : ((raw_len > MAX) ? MAX : raw_len);
        m_lfsr = SEED;
        if (!mode) begin
            for (int k = 0; k < m_len; k++) m_code[k] = m_step();
        end
    endfunction

    function automatic void model_symbol(input bit s);
        bit d;
        for (int k = 0; k < m_len; k++) begin
            d = m_mode ? m_step() : m_code[k];
            exp_q.push_back({(k == m_len - 1), d ^ s});
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_config(input bit mode, input logic [LW-1:0] len);
        int n;
        i_code_mode  = mode;
        i_spread_len = len;
        i_valid      = 1'b0;
        i_reload     = 1'b1;
        cyc();
        i_reload = 1'b0;
        n = 0;
        while (!o_ready && n < 200) begin
            cyc();
            n++;
        end
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL config_wait: o_ready=%b after %0d cycles, required 1", o_ready, n);
        end
        model_config(mode, int'(len));
    endtask

    // Feeds sym_in and records every handshaked chip into got_q.
    task automatic drive_stream(input int ready_pct);
        int idx;
        int cyc_n;
        bit first_seen;
        idx = 0;
        cyc_n = 0;
        first_seen = 0;
        gaps = 0;
        stream_to = 0;
        got_q.delete();
        forever begin
            if (idx == sym_in.size() && !o_valid) break;
            if (cyc_n > 3000) begin
                stream_to = 1;
                break;
            end
            if (first_seen && !o_valid && idx < sym_in.size()) gaps++;
            i_valid = (idx < sym_in.size());
            i_data  = 1'b0;
            if (i_valid) i_data = sym_in[idx];
            i_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (o_valid) first_seen = 1;
            if (o_valid && i_ready) got_q.push_back({o_last, o_data});
            if (i_valid && o_ready) idx++;
            cyc();
            cyc_n++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        logic [1:0] lit [0:7];
        i_reset = 1'b1;
        i_code_mode = 1'b0;
        i_spread_len = LW'(4);
        i_valid = 1'b1;
        i_ready = 1'b1;
        repeat (2) cyc();
        n_tests++;
        if ({o_valid, o_last, o_ready, o_code_ready, o_data} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: v/l/r/cr/d=%b, required 00000",
                     {o_valid, o_last, o_ready, o_code_ready, o_data});
        end
        i_reset = 1'b0;
        i_valid = 1'b0;
        #1;
        n = 0;
        while (!o_ready && n < 100) begin
            n++;
            cyc();
        end
        n_tests++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL reset_gen_len: o_ready low %0d cycles, required 4", n);
        end
        model_config(1'b0, 4);
        lit = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b10};
        sym_in = '{1'b1, 1'b0};
        drive_stream(100);
        n_tests++;
        if (got_q.size() !== 8 || stream_to) begin
            n_fail++;
            $display("FAIL short_directed_count: %0d chips (timeout=%0b), required 8", got_q.size(), stream_to);
        end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            n_tests++;
            if (got_q[i] !== lit[i]) begin
                n_fail++;
                $display("FAIL short_directed_chip%0d: {last,data}=%b, required %b", i, got_q[i], lit[i]);
            end
        end
    endtask

    task automatic test_short_code();
        for (int r = 0; r < 4; r++) begin
            do_config(1'b0, LW'($urandom_range(2, 24)));
            sym_in.delete();
            exp_q.delete();
            for (int s = 0; s < 4; s++) begin
                sym_in.push_back(1'($urandom_range(0, 1)));
                model_symbol(sym_in[s]);
            end
            drive_stream(70);
            n_tests++;
            if (got_q.size() !== exp_q.size() || stream_to) begin
                n_fail++;
                $display("FAIL short_rand%0d_count: %0d chips, required %0d", r, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL short_rand%0d_chip%0d: %b, required %b", r, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit lit [0:5];
        lit = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_config(1'b1, LW'(4));
        exp_q.delete();
        sym_in = '{1'b1, 1'b0, 1'b1};
        foreach (sym_in[s]) model_symbol(sym_in[s]);
        drive_stream(100);
        n_tests++;
        if (gaps !== 0 || got_q.size() !== 12 || stream_to) begin
            n_fail++;
            $display("FAIL long_b2b: gaps=%0d chips=%0d, required gaps=0 chips=12", gaps, got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i][0] !== lit[i]) begin
                n_fail++;
                $display("FAIL long_pn_chip%0d: %b, required %b", i, got_q[i][0], lit[i]);
            end
        end
        for (int r = 0; r < 3; r++) begin
            if (r > 0) do_config(1'b1, LW'($urandom_range(2, 16)));
            if (r == 0) exp_q.delete();
            if (r > 0) exp_q.delete();
            sym_in.delete();
            for (int s = 0; s < 5; s++) sym_in.push_back(1'($urandom_range(0, 1)));
            if (r == 0) begin
                // continue the free-running PN of the previous stream
                foreach (sym_in[s]) model_symbol(sym_in[s]);
            end else begin
                foreach (sym_in[s]) model_symbol(sym_in[s]);
            end
            drive_stream((r == 2) ? 100 : 60);
            n_tests++;
            if (got_q.size() !== exp_q.size() || stream_to || (r == 2 && gaps !== 0)) begin
                n_fail++;
                $display("FAIL long_rand%0d: chips=%0d gaps=%0d, required chips=%0d", r, got_q.size(), gaps, exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL long_rand%0d_chip%0d: %b, required %b", r, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] e;
        for (int m = 0; m < 2; m++) begin
            do_config(1'(m), LW'(8));
            exp_q.delete();
            i_data  = 1'($urandom_range(0, 1));
            model_symbol(i_data);
            i_valid = 1'b1;
            i_ready = 1'b1;
            #1;
            cyc();
            i_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (k == 3) begin
                    i_ready = 1'b0;
                    repeat (5) begin
                        #1;
                        n_tests++;
                        if ({o_valid, o_last, o_data} !== {1'b1, exp_q[0]}) begin
                            n_fail++;
                            $display("FAIL bp_hold_m%0d: v/l/d=%b, required %b", m,
                                     {o_valid, o_last, o_data}, {1'b1, exp_q[0]});
                        end
                        cyc();
                    end
                    i_ready = 1'b1;
                end
                e = exp_q.pop_front();
                #1;
                n_tests++;
                if ({o_valid, o_last, o_data} !== {1'b1, e}) begin
                    n_fail++;
                    $display("FAIL bp_chip_m%0d_%0d: v/l/d=%b, required %b", m, k,
                             {o_valid, o_last, o_data}, {1'b1, e});
                end
                cyc();
            end
            n_tests++;
            if (o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_end_m%0d: o_valid=%b, required 0", m, o_valid);
            end
        end
    endtask

    task automatic test_clamp();
        logic [LW-1:0] big;
        for (int c = 0; c < 2; c++) begin
            big = LW'(200);
            do_config(1'b0, (c == 0) ? LW'(0) : big);
            exp_q.delete();
            sym_in = '{1'b1, 1'b0};
            foreach (sym_in[s]) model_symbol(sym_in[s]);
            drive_stream(100);
            n_tests++;
            if (got_q.size() !== ((c == 0) ? 4 : 128) || stream_to) begin
                n_fail++;
                $display("FAIL clamp%0d_count: %0d chips, required %0d", c, got_q.size(), (c == 0) ? 4 : 128);
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL clamp%0d_chip%0d: %b, required %b", c, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reload_mid_symbol();
        bit s_a, s_b;
        int n;
        logic [1:0] e;
        do_config(1'b0, LW'(4));
        exp_q.delete();
        s_a = 1'($urandom_range(0, 1));
        s_b = 1'($urandom_range(0, 1));
        model_symbol(s_a);
        i_valid = 1'b1;
        i_data  = s_a;
        i_ready = 1'b1;
        #1;
        cyc();
        i_data = s_b;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                i_reload = 1'b1;
                i_spread_len = LW'(6);
            end
            e = exp_q.pop_front();
            #1;
            n_tests++;
            if ({o_valid, o_last, o_data, o_ready} !== {1'b1, e, 1'b0}) begin
                n_fail++;
                $display("FAIL reload_chip%0d: v/l/d/r=%b, required %b", k,
                         {o_valid, o_last, o_data, o_ready}, {1'b1, e, 1'b0});
            end
            cyc();
            i_reload = 1'b0;
        end
        model_config(1'b0, 6);
        model_symbol(s_b);
        n = 0;
        while (!o_ready && n < 100) begin
            n++;
            cyc();
        end
        n_tests++;
        if (n !== 6) begin
            n_fail++;
            $display("FAIL reload_gen_len: o_ready low %0d cycles, required 6", n);
        end
        cyc();
        i_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({o_valid, o_last, o_data} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL reload_new_chip%0d: v/l/d=%b, required %b", k,
                         {o_valid, o_last, o_data}, {1'b1, e});
            end
            cyc();
        end
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_new_end: o_valid=%b, required 0", o_valid);
        end
    endtask

    task automatic test_reset_mid_send();
        int n;
        do_config(1'b0, LW'(4));
        i_valid = 1'b1;
        i_data  = 1'b1;
        i_ready = 1'b1;
        #1;
        cyc();
        i_valid = 1'b0;
        cyc();
        i_reset = 1'b1;
        i_spread_len = LW'(5);
        cyc();
        i_reset = 1'b0;
        n_tests++;
        if ({o_valid, o_code_ready, o_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_send: v/cr/r=%b, required 000", {o_valid, o_code_ready, o_ready});
        end
        n = 0;
        while (!o_ready && n < 100) begin
            n++;
            cyc();
        end
        n_tests++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL reset_mid_gen_len: o_ready low %0d cycles, required 5", n);
        end
        model_config(1'b0, 5);
        exp_q.delete();
        sym_in = '{1'b0};
        model_symbol(1'b0);
        drive_stream(100);
        n_tests++;
        if (got_q.size() !== 5 || stream_to) begin
            n_fail++;
            $display("FAIL reset_resume_count: %0d chips, required 5", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL reset_resume_chip%0d: %b, required %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reload_accept();
        int n;
        do_config(1'b0, LW'(3));
        i_valid  = 1'b1;
        i_data   = 1'b1;
        i_reload = 1'b1;
        #1;
        n_tests++;
        if (o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_ready: o_ready=%b, required 0", o_ready);
        end
        cyc();
        i_reload = 1'b0;
        i_valid  = 1'b0;
        n_tests++;
        if ({o_valid, o_code_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL collide_gen: v/cr=%b, required 00", {o_valid, o_code_ready});
        end
        n = 0;
        while (!o_ready && n < 100) begin
            n++;
            cyc();
        end
        n_tests++;
        if (n !== 3) begin
            n_fail++;
            $display("FAIL collide_gen_len: o_ready low %0d cycles, required 3", n);
        end
        repeat (2) begin
            cyc();
            n_tests++;
            if (o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL collide_consumed: o_valid=%b, required 0", o_valid);
            end
        end
        model_config(1'b0, 3);
        exp_q.delete();
        sym_in = '{1'b1};
        model_symbol(1'b1);
        drive_stream(100);
        n_tests++;
        if (got_q.size() !== 3 || stream_to) begin
            n_fail++;
            $display("FAIL collide_after_count: %0d chips, required 3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL collide_after_chip%0d: %b, required %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_code();
        test_back_to_back();
        test_backpressure();
        test_clamp();
        test_reload_mid_symbol();
        test_reset_mid_send();
        test_reload_accept();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
